// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared constants, width helper and weight-vector type for
//                the spiking neural network column (neurons, array, STDP).
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

  // Width of an unsigned weighted spike sum over rf synapses of wbits each.
  // The worst case rf * (2^wbits - 1) always fits in this width.
  function automatic int sum_bits(input int rf, input int wbits);
    return wbits + $clog2(rf + 1);
  endfunction

  // Default column geometry
  localparam int c_def_rf       = 16;
  localparam int c_def_wbits    = 3;
  localparam int c_def_pot_bits = 8;
  localparam int c_def_sum_bits = sum_bits(c_def_rf, c_def_wbits);
  localparam int c_def_v_bits   = c_def_pot_bits + c_def_sum_bits + 1;

  // Packed per-synapse weight vector, [synapse][weight bit]
  typedef logic [c_def_rf-1:0][c_def_wbits-1:0] weight_vec_t;

endpackage
`default_nettype wire

// File: rtl/lif_neuron_if.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_if
//  Description : Step/spike bundle between a spike source and one LIF neuron.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lif_neuron_if
  import snn_pkg::*;
#(
  parameter int RF       = c_def_rf,
  parameter int WBITS    = c_def_wbits,
  parameter int POT_BITS = c_def_pot_bits
);

  logic                          step_valid;
  logic [RF-1:0]                 spikes_in;
  logic [RF-1:0][WBITS-1:0]      weights;
  logic                          inhibit;
  logic                          spike_out;
  logic [POT_BITS-1:0]           potential;
  logic                          refractory;

  // Spike source / stimulus side
  modport master (
    output step_valid, spikes_in, weights, inhibit,
    input  spike_out, potential, refractory
  );

  // Neuron side
  modport slave (
    input  step_valid, spikes_in, weights, inhibit,
    output spike_out, potential, refractory
  );

endinterface
`default_nettype wire

// File: rtl/snn_weighted_sum.sv
`default_nettype none
// ============================================================================
//  Module      : snn_weighted_sum
//  Description : Combinational adder tree computing sum(spikes_in[i]*w[i]).
//                Leaves are padded to a power of two with zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_weighted_sum
  import snn_pkg::*;
#(
  parameter int RF       = c_def_rf,
  parameter int WBITS    = c_def_wbits,
  parameter int SUM_BITS = sum_bits(RF, WBITS)
) (
  input  wire logic [RF-1:0]            spikes_in,
  input  wire logic [RF-1:0][WBITS-1:0] weights,
  output logic      [SUM_BITS-1:0]      sum
);

  localparam int c_levels = $clog2(RF);
  localparam int c_leaves = 1 << c_levels;

  // Heap-ordered tree: node n has children 2n and 2n+1, leaves at c_leaves..
  logic [SUM_BITS-1:0] w_tree [1:2*c_leaves-1];

  // Gate each weight by its spike, then reduce pairwise towards the root
  always_comb begin
    for (int i = 0; i < c_leaves; i++) begin
      w_tree[c_leaves + i] = '0;
    end
    for (int i = 0; i < RF; i++) begin
      if (spikes_in[i]) begin
        w_tree[c_leaves + i] = SUM_BITS'(weights[i]);
      end
    end
    for (int n = c_leaves - 1; n >= 1; n--) begin
      w_tree[n] = w_tree[2*n] + w_tree[2*n + 1];
    end
  end

  assign sum = w_tree[1];

endmodule
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron
//  Description : Two-stage leaky integrate-and-fire neuron. Stage 1 registers
//                the weighted spike sum; stage 2 integrates it into a
//                saturating membrane potential with leak, threshold fire,
//                refractory hold-off and lateral inhibit.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron
  import snn_pkg::*;
#(
  parameter int RF        = c_def_rf,
  parameter int WBITS     = c_def_wbits,
  parameter int POT_BITS  = c_def_pot_bits,
  parameter int THRESHOLD = 8,
  parameter int LEAK      = 1,
  parameter int REFRAC    = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  lif_neuron_if.slave   nif
);

  localparam int c_sum_bits = sum_bits(RF, WBITS);
  // One extra sign bit over potential+sum so the subtraction cannot wrap
  localparam int c_v_bits   = POT_BITS + c_sum_bits + 1;
  // A 1-bit counter that is never loaded keeps REFRAC = 0 legal
  localparam int c_ref_bits = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [c_ref_bits-1:0] c_refrac_load = c_ref_bits'(REFRAC);
  localparam logic [POT_BITS-1:0]   c_threshold   = POT_BITS'(THRESHOLD);
  localparam logic [c_v_bits-1:0]   c_leak        = c_v_bits'(LEAK);
  localparam logic [POT_BITS-1:0]   c_pot_max     = '1;

  logic [c_sum_bits-1:0]    w_sum;
  logic [c_sum_bits-1:0]    r_sum_q;
  logic                     r_s1_valid;
  logic [POT_BITS-1:0]      r_potential;
  logic [c_ref_bits-1:0]    r_ref_cnt;
  logic                     r_spike;
  logic signed [c_v_bits-1:0] w_v;
  logic [POT_BITS-1:0]      w_clamped;
  logic                     w_fire;
  logic                     w_ref_active;

  snn_weighted_sum #(
    .RF       (RF),
    .WBITS    (WBITS),
    .SUM_BITS (c_sum_bits)
  ) u_wsum (
    .spikes_in (nif.spikes_in),
    .weights   (nif.weights),
    .sum       (w_sum)
  );

  // Stage 1: capture the weighted sum on each time-step strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_q    <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= nif.step_valid;
      if (nif.step_valid) begin
        r_sum_q <= w_sum;
      end
    end
  end

  // Candidate potential: leak applied, clamped to [0, max], then compared
  always_comb begin
    w_v = $signed({{(c_v_bits - POT_BITS){1'b0}}, r_potential})
        + $signed({{(c_v_bits - c_sum_bits){1'b0}}, r_sum_q})
        - $signed(c_leak);
    if (w_v[c_v_bits-1]) begin
      w_clamped = '0;
    end else if (|w_v[c_v_bits-2:POT_BITS]) begin
      w_clamped = c_pot_max;
    end else begin
      w_clamped = w_v[POT_BITS-1:0];
    end
    w_fire = (w_clamped > c_threshold);
  end

  assign w_ref_active = (r_ref_cnt != '0);

  // Stage 2: refractory countdown, integrate/fire, inhibit overrides update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_potential <= '0;
      r_ref_cnt   <= '0;
      r_spike     <= 1'b0;
    end else begin
      r_spike <= 1'b0;
      // The countdown runs on integrated steps even while inhibited
      if (r_s1_valid && w_ref_active) begin
        r_ref_cnt <= r_ref_cnt - c_ref_bits'(1);
      end
      if (nif.inhibit) begin
        r_potential <= '0;
      end else if (r_s1_valid) begin
        if (w_ref_active) begin
          r_potential <= '0;
        end else if (w_fire) begin
          r_spike     <= 1'b1;
          r_potential <= '0;
          r_ref_cnt   <= c_refrac_load;
        end else begin
          r_potential <= w_clamped;
        end
      end
    end
  end

  assign nif.spike_out  = r_spike;
  assign nif.potential  = r_potential;
  assign nif.refractory = w_ref_active;

endmodule
`default_nettype wire

// File: doc/lif_neuron.md
# lif_neuron

Parametrised, clocked leaky integrate-and-fire neuron; successor to the combinational threshold neuron. Each time-step strobe computes a weighted spike sum over the receptive field, then integrates it into a saturating membrane potential with per-step leak. The neuron fires when the potential crosses threshold, then resets and enters a programmable refractory period. An external inhibit input supports lateral inhibition. One instance per output neuron in the column array.

## Interface
- RF, 16: receptive field size (number of input synapses)
- WBITS, 3: weight width, unsigned
- POT_BITS, 8: membrane potential width, unsigned
- THRESHOLD, 8: fire when potential > THRESHOLD; must be < 2^POT_BITS
- LEAK, 1: amount subtracted from the potential per integrated step
- REFRAC, 2: number of steps ignored after a spike; 0 disables the refractory period
- clk  in  1  clock; everything is synchronous to the rising edge
- rst  in  1  synchronous, active-high reset
- step_valid  in  1  time-step strobe; spikes_in and weights are sampled on the same edge
- spikes_in  in  RF  one bit per synapse
- weights  in  RF x WBITS  per-synapse weight, packed [RF-1:0][WBITS-1:0]
- inhibit  in  1  clears the potential; highest priority after rst
- spike_out  out  1  one-cycle output spike pulse
- potential  out  POT_BITS  current membrane potential (registered)
- refractory  out  1  high while the refractory count is nonzero

## Operation
- SUM_BITS = WBITS + clog2(RF+1). The sum cannot overflow.
- Stage 1: on an edge where step_valid=1, register sum_q = Σ spikes_in[i]·weights[i] and set s1_valid. Otherwise s1_valid = 0.
- Stage 2, on an edge where s1_valid=1, in priority order:
  - If ref_cnt != 0: decrement ref_cnt. Hold potential at 0. spike_out = 0.
  - Otherwise compute v = potential + sum_q − LEAK at POT_BITS+SUM_BITS+1 bits, signed:
    - Clamp v to [0, 2^POT_BITS−1].
    - If clamped v > THRESHOLD: spike_out = 1, potential = 0, ref_cnt = REFRAC.
    - Else: potential = clamped v, spike_out = 0.
- Leak is applied only on integrated steps, never on idle cycles. Idle cycles hold the potential unchanged.
- Threshold compare uses the clamped value. If THRESHOLD = 2^POT_BITS−1, the neuron can never fire.
- inhibit sampled high:
  - potential = 0 and spike_out = 0.
  - Any stage-2 update on that edge is discarded and ref_cnt is not loaded.
  - An active ref_cnt still decrements if s1_valid=1.
  - Stage 1 is unaffected; in-flight data integrates on the next edge.
- rst: potential = 0, ref_cnt = 0, s1_valid = 0, sum_q = 0, spike_out = 0. All in-flight steps are dropped.

## Timing
- Reset values: spike_out = 0, potential = 0, refractory = 0.
- Latency: step_valid sampled at edge t → potential/spike_out updated at edge t+1. spike_out is high for exactly the cycle after edge t+1.
- Throughput: one step per cycle. Back-to-back step_valid is legal with no stall and no ready signal.
- spike_out is never high for two consecutive cycles when REFRAC ≥ 1. With REFRAC = 0, consecutive spikes are legal.
- refractory reflects ref_cnt != 0 after each edge. It rises in the same cycle spike_out is high.
- rst asserted at t+1 after step_valid at t: no spike is produced.

## Structure
- Package snn_pkg:
  - sum_bits(RF, WBITS) function
  - potential/sum width constants
  - a typedef for the packed weight vector, shared with the array and the future STDP learning block
- Sub-module snn_weighted_sum: combinational, parametrised adder tree producing SUM_BITS. Instantiated for stage 1 and reused by other neuron variants.
- lif_neuron holds the stage-1 registers, the potential/ref_cnt datapath, and the compare.

## Test plan
- Reset (defaults): hold rst 3 cycles with random inputs → spike_out = 0, potential = 0, refractory = 0 throughout and one cycle after release.
- Integrate and fire: 3 inputs active, weight 2 each (sum 6). Step 1 → potential 5. Step 2 → 10 > 8, so spike_out pulses once, potential = 0, refractory = 1.
- Refractory: continue the previous case with two steps, all 16 inputs at weight 7. Both steps are ignored: potential stays 0, refractory falls after the 2nd step. The 3rd step gives potential 111 → >8, so it fires.
- Leak floor and saturation:
  - No spikes from potential 0 → potential stays 0.
  - With THRESHOLD = 255, all inputs at weight 7: potential 111 → 222 → 255 → 255, and spike_out is never asserted.
- Inhibit coincident with a firing update: potential 5, step with sum 6, inhibit high on the integrate edge → no spike, potential = 0, refractory = 0.
- Back-to-back steps plus mid-pipeline reset:
  - Steps every cycle with sum 3 → potentials 2, 4, 6, 8, then a spike on the 5th step.
  - Repeat with rst one cycle after a step that would fire → no spike.
